// File: rtl/spawn_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spawn_queue_pkg : shared state encoding and ring-pointer helpers     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spawn_queue_pkg;

  typedef enum logic [2:0] {
    WAITING = 3'd0,
    RUNNING = 3'd1,
    SPAWN   = 3'd2,
    SETTLE  = 3'd3,
    RETIRE  = 3'd4,
    CLEAR   = 3'd5,
    CRASHED = 3'd6
  } state_t;

  localparam int TYPE_NONE = 0;

  // Ring pointers are at most 4 bits wide because the slot count stays below 16.
  function automatic logic [3:0] incr_mod(input logic [3:0] v, input logic [3:0] n);
    return (v == n - 4'd1) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] decr_mod(input logic [3:0] v, input logic [3:0] n);
    return (v == 4'd0) ? n - 4'd1 : v - 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spawn_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spawn_queue_if : control inputs, slot status and queue outputs       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface spawn_queue_if #(
  parameter int NUM_SLOTS = 7,
  parameter int NUM_TYPES = 3,
  parameter int TYPE_W    = $clog2(NUM_TYPES + 1)
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic                               start;
  logic                               crash;
  logic                               update;
  logic                               spawn_en;
  logic [10:0]                        rng;
  logic [NUM_TYPES-1:0]               type_allowed;
  logic [NUM_SLOTS-1:0]               slot_visible;
  logic [NUM_SLOTS-1:0]               slot_remove;
  logic [NUM_SLOTS-1:0][10:0]         slot_x_pos;
  logic [NUM_SLOTS-1:0][9:0]          slot_width;
  logic [NUM_SLOTS-1:0][10:0]         slot_gap;

  logic [NUM_SLOTS-1:0]               slot_start;
  logic [NUM_SLOTS-1:0][TYPE_W-1:0]   slot_type;
  logic                               slot_update;
  logic [IDX_W-1:0]                   front_idx;
  logic                               lead_valid;
  logic [CNT_W-1:0]                   count;
  logic                               frame_done;
  logic                               overrun;

  modport master (
    output start, crash, update, spawn_en, rng, type_allowed,
           slot_visible, slot_remove, slot_x_pos, slot_width, slot_gap,
    input  slot_start, slot_type, slot_update, front_idx, lead_valid,
           count, frame_done, overrun
  );

  modport slave (
    input  start, crash, update, spawn_en, rng, type_allowed,
           slot_visible, slot_remove, slot_x_pos, slot_width, slot_gap,
    output slot_start, slot_type, slot_update, front_idx, lead_valid,
           count, frame_done, overrun
  );

endinterface
`default_nettype wire

// File: rtl/spawn_queue_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spawn_type_picker : rotates through types from an rng offset and     |
// | returns the first allowed, non-duplicating one (or NONE)             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spawn_type_picker
  import spawn_queue_pkg::*;
#(
  parameter int NUM_TYPES = 3,
  parameter int TYPE_W    = $clog2(NUM_TYPES + 1),
  parameter int MAX_DUP   = 2,
  parameter int DUP_W     = (MAX_DUP == 0) ? 1 : MAX_DUP,
  parameter int CNT_W     = 3
) (
  input  logic [10:0]                   rng,
  input  logic [NUM_TYPES-1:0]          type_allowed,
  input  logic [DUP_W-1:0][TYPE_W-1:0]  recent_types,
  input  logic [CNT_W-1:0]              recent_cnt,
  output logic [TYPE_W-1:0]             pick_type
);
  localparam int RW = TYPE_W + 1;

  logic [RW-1:0]        acc;
  logic [RW-1:0]        cand;
  logic [TYPE_W-1:0]    t;
  logic [NUM_TYPES-1:0] allow_vec;
  logic                 dup;
  logic                 found;

  always_comb begin
    acc       = '0;
    cand      = '0;
    t         = '0;
    allow_vec = '0;
    dup       = 1'b0;
    found     = 1'b0;
    pick_type = TYPE_W'(TYPE_NONE);

    // Bit-serial remainder: the residue stays below NUM_TYPES, so one
    // conditional subtract per rng bit is enough.
    for (int b = 10; b >= 0; b--) begin
      acc = {acc[TYPE_W-1:0], rng[b]};
      if (acc >= RW'(NUM_TYPES)) acc = acc - RW'(NUM_TYPES);
    end

    for (int i = 0; i < NUM_TYPES; i++) begin
      cand = acc + RW'(i);
      if (cand >= RW'(NUM_TYPES)) cand = cand - RW'(NUM_TYPES);
      t         = TYPE_W'(cand + RW'(1));
      allow_vec = type_allowed >> cand;
      dup       = (MAX_DUP != 0) && (int'(recent_cnt) >= MAX_DUP);
      for (int k = 0; k < DUP_W; k++) begin
        if (recent_types[k] != t) dup = 1'b0;
      end
      if (!found && allow_vec[0] && !dup) begin
        pick_type = t;
        found     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spawn_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spawn_queue : per-frame ring scheduler for scrolling entity slots    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spawn_queue
  import spawn_queue_pkg::*;
#(
  parameter int NUM_SLOTS     = 7,
  parameter int NUM_TYPES     = 3,
  parameter int TYPE_W        = $clog2(NUM_TYPES + 1),
  parameter int MAX_DUP       = 2,
  parameter int GAME_WIDTH    = 640,
  parameter int RNG_GATE      = 0,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  spawn_queue_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int DUP_W = (MAX_DUP == 0) ? 1 : MAX_DUP;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 front_q, front_d;
  logic [IDX_W-1:0]                 back_q, back_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic [NUM_SLOTS-1:0]             slot_start_q, slot_start_d;
  logic [NUM_SLOTS-1:0][TYPE_W-1:0] slot_type_q, slot_type_d;
  logic                             slot_update_q, slot_update_d;
  logic                             frame_done_q, frame_done_d;
  logic                             overrun_q, overrun_d;
  logic                             lead_valid_q, lead_valid_d;
  logic [2:0]                       settle_q, settle_d;

  logic [IDX_W-1:0]                 last_idx;
  logic [3:0]                       ptr;
  logic [DUP_W-1:0][TYPE_W-1:0]     recent_types;
  logic [TYPE_W-1:0]                pick_type;
  logic [12:0]                      gap_sum;
  logic                             gap_ok;
  logic                             spawn_ok;
  logic                             pop_ok;

  assign last_idx = IDX_W'(decr_mod(4'(back_q), 4'(NUM_SLOTS)));

  // Walk backwards from the newest entry to collect the duplication window.
  always_comb begin
    ptr          = 4'(back_q);
    recent_types = '0;
    for (int k = 0; k < DUP_W; k++) begin
      ptr             = decr_mod(ptr, 4'(NUM_SLOTS));
      recent_types[k] = slot_type_q[ptr[IDX_W-1:0]];
    end
  end

  spawn_type_picker #(
    .NUM_TYPES (NUM_TYPES),
    .TYPE_W    (TYPE_W),
    .MAX_DUP   (MAX_DUP),
    .DUP_W     (DUP_W),
    .CNT_W     (CNT_W)
  ) u_picker (
    .rng          (bus.rng),
    .type_allowed (bus.type_allowed),
    .recent_types (recent_types),
    .recent_cnt   (count_q),
    .pick_type    (pick_type)
  );

  assign gap_sum = {{2{bus.slot_x_pos[last_idx][10]}}, bus.slot_x_pos[last_idx]}
                 + {3'b000, bus.slot_width[last_idx]}
                 + {2'b00, bus.slot_gap[last_idx]};

  assign gap_ok   = (count_q == '0) ||
                    (bus.slot_visible[last_idx] && ($signed(gap_sum) < $signed(13'(GAME_WIDTH))));
  assign spawn_ok = bus.spawn_en && (count_q != CNT_W'(NUM_SLOTS)) &&
                    ((RNG_GATE == 0) || bus.rng[0]) && gap_ok &&
                    (pick_type != TYPE_W'(TYPE_NONE));
  assign pop_ok   = (count_q != '0) && bus.slot_remove[front_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAITING;
      front_q       <= '0;
      back_q        <= '0;
      count_q       <= '0;
      slot_start_q  <= '0;
      slot_type_q   <= '0;
      slot_update_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      lead_valid_q  <= 1'b0;
      settle_q      <= '0;
    end else begin
      state_q       <= state_d;
      front_q       <= front_d;
      back_q        <= back_d;
      count_q       <= count_d;
      slot_start_q  <= slot_start_d;
      slot_type_q   <= slot_type_d;
      slot_update_q <= slot_update_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      lead_valid_q  <= lead_valid_d;
      settle_q      <= settle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAITING: if (bus.start) state_d = RUNNING;
      RUNNING: begin
        if (bus.crash)       state_d = CRASHED;
        else if (bus.update) state_d = SPAWN;
      end
      SPAWN:   state_d = bus.crash ? CRASHED : SETTLE;
      SETTLE: begin
        if (bus.crash)                               state_d = CRASHED;
        else if (settle_q == 3'(SETTLE_CYCLES - 1))  state_d = RETIRE;
      end
      RETIRE: begin
        if (bus.crash)   state_d = CRASHED;
        else if (!pop_ok) state_d = RUNNING;
      end
      CLEAR:   state_d = RUNNING;
      CRASHED: if (bus.start) state_d = CLEAR;
      default: state_d = WAITING;
    endcase
  end

  always_comb begin
    front_d       = front_q;
    back_d        = back_q;
    count_d       = count_q;
    slot_start_d  = slot_start_q;
    slot_type_d   = slot_type_q;
    slot_update_d = 1'b0;
    frame_done_d  = 1'b0;
    overrun_d     = overrun_q;
    settle_d      = '0;

    if ((state_q inside {SPAWN, SETTLE, RETIRE, CLEAR}) && bus.update) overrun_d = 1'b1;

    case (state_q)
      SPAWN: begin
        if (!bus.crash) begin
          slot_update_d = 1'b1;
          if (spawn_ok) begin
            slot_start_d[back_q] = 1'b1;
            slot_type_d[back_q]  = pick_type;
            back_d               = IDX_W'(incr_mod(4'(back_q), 4'(NUM_SLOTS)));
            count_d              = count_q + CNT_W'(1);
          end
        end
      end
      SETTLE: begin
        if (!bus.crash && (settle_q != 3'(SETTLE_CYCLES - 1))) settle_d = settle_q + 3'd1;
      end
      RETIRE: begin
        if (!bus.crash) begin
          if (pop_ok) begin
            slot_start_d[front_q] = 1'b0;
            front_d               = IDX_W'(incr_mod(4'(front_q), 4'(NUM_SLOTS)));
            count_d               = count_q - CNT_W'(1);
          end else begin
            frame_done_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        front_d      = '0;
        back_d       = '0;
        count_d      = '0;
        slot_start_d = '0;
        slot_type_d  = '0;
      end
      default: ;
    endcase

    lead_valid_d = (count_d != '0);
  end

  assign bus.slot_start  = slot_start_q;
  assign bus.slot_type   = slot_type_q;
  assign bus.slot_update = slot_update_q;
  assign bus.front_idx   = front_q;
  assign bus.lead_valid  = lead_valid_q;
  assign bus.count       = count_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spawn_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spawn_queue : directed bench with a per-frame expectation queue   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_spawn_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spawn_queue_if #(.NUM_SLOTS(7), .NUM_TYPES(3)) bus ();

  spawn_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] cnt;
    logic [6:0] st;
    logic [2:0] fr;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_frame(input logic [3:0] c, input logic [6:0] s, input logic [2:0] f);
    exp_t e;
    e.cnt = c;
    e.st  = s;
    e.fr  = f;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for frame_done, then compare against the oldest expectation.
  task automatic wait_frame(input string tag);
    exp_t e;
    logic got;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (bus.frame_done) got = 1'b1;
    end
    chk({tag, "_frame_done"}, 32'(got), 32'd1);
    e = exp_q.pop_front();
    chk({tag, "_count"}, 32'(bus.count), 32'(e.cnt));
    chk({tag, "_slot_start"}, 32'(bus.slot_start), 32'(e.st));
    chk({tag, "_front"}, 32'(bus.front_idx), 32'(e.fr));
  endtask

  task automatic run_frame(input string tag, input logic [3:0] c, input logic [6:0] s,
                           input logic [2:0] f);
    expect_frame(c, s, f);
    bus.update = 1'b1;
    tick();
    bus.update = 1'b0;
    wait_frame(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_fd;

    bus.start        = 1'b0;
    bus.crash        = 1'b0;
    bus.update       = 1'b0;
    bus.spawn_en     = 1'b1;
    bus.rng          = 11'd0;
    bus.type_allowed = 3'b111;
    bus.slot_visible = 7'h7F;
    bus.slot_remove  = 7'h00;
    for (int i = 0; i < 7; i++) begin
      bus.slot_x_pos[i] = 11'h79C;   // -100: far left of the screen
      bus.slot_width[i] = 10'd10;
      bus.slot_gap[i]   = 11'd10;
    end

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_slot_start", 32'(bus.slot_start), 32'd0);
    chk("rst_slot_type", 32'(bus.slot_type), 32'd0);
    chk("rst_lead_valid", 32'(bus.lead_valid), 32'd0);
    chk("rst_outputs", 32'({bus.slot_update, bus.frame_done, bus.overrun}), 32'd0);
    chk("rst_front", 32'(bus.front_idx), 32'd0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;

    // First spawn into an empty queue; strobe lands in the third cycle
    // counting the update cycle itself (update, SPAWN, strobe).
    expect_frame(4'd1, 7'b0000001, 3'd0);
    bus.update = 1'b1;
    tick();
    bus.update = 1'b0;
    chk("t1_strobe_early", 32'(bus.slot_update), 32'd0);
    tick();
    chk("t1_strobe", 32'(bus.slot_update), 32'd1);
    chk("t1_slot0", 32'(bus.slot_start[0]), 32'd1);
    chk("t1_lead_valid", 32'(bus.lead_valid), 32'd1);
    tick();
    chk("t1_strobe_1cyc", 32'(bus.slot_update), 32'd0);
    wait_frame("t1");
    chk("t1_type0", 32'(bus.slot_type[0]), 32'd1);

    // Fill to capacity, then one more frame that must not spawn.
    for (int k = 2; k <= 8; k++) begin
      int c;
      c = (k > 7) ? 7 : k;
      run_frame("t2", 4'(c), 7'((1 << c) - 1), 3'd0);
    end
    chk("t2_types", 32'(bus.slot_type), 32'({2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1}));

    // Three removable entries at the front retire on consecutive cycles.
    bus.spawn_en    = 1'b0;
    bus.slot_remove = 7'b0000111;
    expect_frame(4'd4, 7'b1111000, 3'd3);
    bus.update = 1'b1;
    tick();
    bus.update = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_pop_count", 32'(bus.count), 32'(6 - k));
      chk("t3_no_done_yet", 32'(bus.frame_done), 32'd0);
    end
    wait_frame("t3");
    bus.slot_remove = 7'b0000000;
    bus.spawn_en    = 1'b1;

    // Back pointer has wrapped: next spawn lands in slot 0.
    run_frame("wrap", 4'd5, 7'b1111001, 3'd3);
    chk("wrap_type0", 32'(bus.slot_type[0]), 32'd1);

    // Only type 1 allowed and the last two entries are type 1: blocked.
    bus.type_allowed = 3'b001;
    run_frame("t4", 4'd5, 7'b1111001, 3'd3);

    // rng=1000 -> 1000 mod 3 = 1 -> first candidate is type 2.
    bus.type_allowed = 3'b111;
    bus.rng          = 11'd1000;
    run_frame("rng", 4'd6, 7'b1111011, 3'd3);
    chk("rng_type1", 32'(bus.slot_type[1]), 32'd2);

    // Gap boundary on the newest entry (slot 1): 500+50+90 = 640 blocks.
    bus.slot_x_pos[1] = 11'd500;
    bus.slot_width[1] = 10'd50;
    bus.slot_gap[1]   = 11'd90;
    run_frame("gap640", 4'd6, 7'b1111011, 3'd3);
    bus.slot_gap[1]   = 11'd89;
    run_frame("gap639", 4'd7, 7'b1111111, 3'd3);
    chk("gap639_type2", 32'(bus.slot_type[2]), 32'd2);

    // Update arriving in RETIRE; queue is full so nothing spawns.
    expect_frame(4'd7, 7'b1111111, 3'd3);
    bus.update = 1'b1;
    tick();
    bus.update = 1'b0;
    tick();
    tick();
    chk("ovr_before", 32'(bus.overrun), 32'd0);
    bus.update = 1'b1;
    wait_frame("ovr");
    bus.update = 1'b0;
    chk("ovr_set", 32'(bus.overrun), 32'd1);

    // Crash during SETTLE freezes the queue and suppresses the retire.
    bus.slot_remove = 7'b0001000;
    bus.update = 1'b1;
    tick();
    bus.update = 1'b0;
    tick();
    bus.crash = 1'b1;
    tick();
    bus.crash = 1'b0;
    chk("crash_strobe", 32'(bus.slot_update), 32'd0);
    seen_fd = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.update = (k == 2);
      tick();
      if (bus.frame_done) seen_fd = 1'b1;
    end
    bus.update = 1'b0;
    chk("crash_no_done", 32'(seen_fd), 32'd0);
    chk("crash_count", 32'(bus.count), 32'd7);
    chk("crash_front", 32'(bus.front_idx), 32'd3);
    chk("crash_ovr_sticky", 32'(bus.overrun), 32'd1);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.slot_remove = 7'b0000000;
    chk("clear_count", 32'(bus.count), 32'd0);
    chk("clear_slot_start", 32'(bus.slot_start), 32'd0);
    chk("clear_slot_type", 32'(bus.slot_type), 32'd0);
    chk("clear_front_lead", 32'({bus.front_idx, bus.lead_valid}), 32'd0);
    chk("clear_ovr_sticky", 32'(bus.overrun), 32'd1);
    run_frame("restart", 4'd1, 7'b0000001, 3'd0);
    chk("restart_type0", 32'(bus.slot_type[0]), 32'd2);

    // Crash in SPAWN: no strobe and no spawn.
    bus.update = 1'b1;
    tick();
    bus.update = 1'b0;
    bus.crash  = 1'b1;
    tick();
    bus.crash  = 1'b0;
    chk("crash_spawn_strobe", 32'(bus.slot_update), 32'd0);
    chk("crash_spawn_count", 32'(bus.count), 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_overrun", 32'(bus.overrun), 32'd0);
    chk("rst2_count", 32'(bus.count), 32'd0);
    chk("rst2_slot_start", 32'(bus.slot_start), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
